// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared register offsets, status field positions and key-code helpers
package keypad_scan_pkg;
  typedef enum logic {REG_STATUS = 1'b0, REG_DATA = 1'b1} reg_sel_e;
  typedef logic [3:0] key_code_t;
  localparam int STAT_OVF = 7;
  localparam int STAT_KEYS_LSB = 16;
  localparam int CNT_W = 5;
  localparam int EMPTY_BIT = 31;
  localparam logic [31:0] DATA_EMPTY = 32'(1) << EMPTY_BIT;
  function automatic key_code_t lowest_key(input logic [15:0] v);
    lowest_key = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest_key = key_code_t'(i);
  endfunction
endpackage

// File: rtl/keycode_fifo.sv
// keycode_fifo: DEPTH-entry 4-bit key code FIFO; push while full succeeds only with a same-cycle pop
module keycode_fifo
  import keypad_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  key_code_t        din,
  output key_code_t        dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  key_code_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign dout = mem_q[rd_q];
  assign count = count_q;
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? nxt(wr_q) : wr_q;
    rd_d = do_pop ? nxt(rd_q) : rd_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad scanner with frame debounce, new-key FIFO and two-word bus window
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h20,
  parameter int CNT_BITS = 16,
  parameter int DEBOUNCE = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic [3:0]  row,
  input  logic [3:0]  col
);
  logic [3:0] col_m_q, col_m_d, col_s_q, col_s_d;
  logic [CNT_BITS-1:0] dwell_q, dwell_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [15:0] snap_q, snap_d, prev_q, prev_d, deb_q, deb_d, pend_q, pend_d;
  logic [2:0] stab_q, stab_d;
  logic ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic wrap, frame_end, commit, hit, sel_data, push, pop, ovf_clr, full, empty;
  logic [CNT_W-1:0] count;
  key_code_t dout;
  logic unused_data;
  assign unused_data = ^{data[31:8], data[6:0]};
  assign row = ~(4'b0001 << row_idx_q);
  assign q = rdata_q;
  keycode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(lowest_key(pend_q)),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    col_m_d = col;
    col_s_d = col_m_q;
    wrap = &dwell_q;
    frame_end = wrap && row_idx_q == 2'd3;
    dwell_d = dwell_q + 1'b1;
    row_idx_d = wrap ? row_idx_q + 1'b1 : row_idx_q;
    snap_d = snap_q;
    if (wrap) snap_d[{row_idx_q, 2'b00} +: 4] = ~col_s_q;
    prev_d = frame_end ? snap_d : prev_q;
    stab_d = !frame_end ? stab_q : snap_d != prev_q ? '0 : stab_q == 3'(DEBOUNCE) ? stab_q : stab_q + 1'b1;
    commit = frame_end && stab_d == 3'(DEBOUNCE);
    deb_d = commit ? snap_d : deb_q;
    push = |pend_q;
    pend_d = (pend_q & (pend_q - 1'b1)) | (commit ? snap_d & ~deb_q : '0);
    hit = strobe && addr[31:1] == BASE[31:1];
    sel_data = reg_sel_e'(addr[0]) == REG_DATA;
    pop = hit && !rw && sel_data && !empty;
    ovf_clr = hit && rw && !sel_data && data[STAT_OVF];
    ovf_d = (push && full && !pop) || (ovf_q && !ovf_clr);
    status = '0;
    status[STAT_KEYS_LSB +: 16] = deb_q;
    status[STAT_OVF] = ovf_q;
    status[CNT_W-1:0] = count;
    rdata_d = !hit || rw ? rdata_q : !sel_data ? status : empty ? DATA_EMPTY : {28'b0, dout};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
      dwell_q <= '0;
      row_idx_q <= '0;
      snap_q <= '0;
      prev_q <= '0;
      deb_q <= '0;
      pend_q <= '0;
      stab_q <= '0;
      ovf_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      col_m_q <= col_m_d;
      col_s_q <= col_s_d;
      dwell_q <= dwell_d;
      row_idx_q <= row_idx_d;
      snap_q <= snap_d;
      prev_q <= prev_d;
      deb_q <= deb_d;
      pend_q <= pend_d;
      stab_q <= stab_d;
      ovf_q <= ovf_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-level reference model of the keypad scanner driven by directed and random key patterns
module tb_keypad_scan;
  localparam logic [31:0] BASE = 32'h20;
  localparam int DB = 2;
  logic clk = 0, reset = 1, strobe = 0, rw = 0;
  logic [31:0] addr = 0, data = 0, q;
  logic [3:0] row, col;
  logic [15:0] held = 0;
  logic [15:0] m_prev, m_deb;
  int m_stab;
  logic m_ovf;
  logic [3:0] m_fifo[$];
  logic [31:0] m_q;
  int ecount = 0, n_checks = 0, n_pass = 0;
  keypad_scan #(.BASE(BASE), .CNT_BITS(2), .DEBOUNCE(DB), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .strobe(strobe),
    .rw(rw),
    .addr(addr),
    .data(data),
    .q(q),
    .row(row),
    .col(col)
  );
  always #5 clk = ~clk;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) if (!row[r]) col = ~held[r*4 +: 4];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_prev = 0;
    m_deb = 0;
    m_stab = 0;
    m_ovf = 0;
    m_fifo.delete();
    m_q = 0;
  endtask
  task automatic model_frame(input logic [15:0] s);
    logic [15:0] nb;
    m_stab = s != m_prev ? 0 : m_stab < DB ? m_stab + 1 : DB;
    m_prev = s;
    if (m_stab == DB) begin
      nb = s & ~m_deb;
      m_deb = s;
      for (int i = 0; i < 16; i++)
        if (nb[i]) begin
          if (m_fifo.size() < 4) m_fifo.push_back(4'(i));
          else m_ovf = 1;
        end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
    check("row", {28'b0, row}, {28'b0, ~(4'b0001 << ((ecount / 4) % 4))});
  endtask
  task automatic do_op(input logic [1:0] op);
    logic [31:0] exp;
    string tag;
    rw = 0;
    data = 0;
    addr = BASE;
    case (op)
      2'd0: begin
        tag = "status";
        exp = {m_deb, 8'b0, m_ovf, 2'b0, 5'(m_fifo.size())};
      end
      2'd1: begin
        tag = "data";
        addr = BASE + 1;
        exp = m_fifo.size() > 0 ? {28'b0, m_fifo.pop_front()} : 32'h8000_0000;
      end
      2'd2: begin
        tag = "ovf_clear_hold";
        rw = 1;
        data = 32'h80;
        m_ovf = 0;
        exp = m_q;
      end
      default: begin
        tag = "outside_hold";
        rw = 1'($urandom_range(0, 1));
        data = 32'h80;
        addr = $urandom_range(0, 1) ? 32'h22 : 32'h40 | 32'($urandom_range(0, 1));
        exp = m_q;
      end
    endcase
    strobe = 1;
    tick();
    strobe = 0;
    rw = 0;
    check(tag, q, exp);
    m_q = exp;
  endtask
  task automatic step(input logic [15:0] keys, input logic [7:0] ops, input int nops, input int len);
    held = keys;
    for (int c = 0; c < len; c++)
      if (c >= 10 && c < 10 + nops) do_op(ops[2*(c-10) +: 2]);
      else tick();
    if (len == 16) model_frame(keys);
  endtask
  task automatic apply_reset();
    reset = 1;
    #1;
    check("q_in_reset", q, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    ecount = 0;
    check("row_after_reset", {28'b0, row}, 32'he);
  endtask
  function automatic logic [7:0] ops4(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction
  function automatic logic [15:0] rnd_keys();
    logic [15:0] k;
    do k = 16'($urandom & $urandom); while ($countones(k) > 8);
    return k;
  endfunction
  initial begin
    logic [15:0] keys;
    int seq[6] = '{5, 0, 14, 7, 10, 2};
    @(posedge clk);
    #1;
    apply_reset();
    step(16'h0, ops4(0, 1, 1, 0), 3, 16);
    for (int f = 0; f < 4; f++) step(16'h0200, 0, 0, 16);
    step(16'h0200, ops4(0, 1, 1, 0), 3, 16);
    for (int f = 0; f < 3; f++) step(16'h0, 0, 0, 16);
    step(16'h0, ops4(0, 1, 0, 0), 2, 16);
    for (int f = 0; f < 6; f++) step(f % 2 ? 16'h0 : 16'h0200, ops4(0, 0, 0, 0), 1, 16);
    for (int f = 0; f < 3; f++) step(16'h0, 0, 0, 16);
    for (int f = 0; f < 3; f++) step(16'h1008, 0, 0, 16);
    step(16'h1008, ops4(1, 1, 1, 0), 4, 16);
    for (int f = 0; f < 3; f++) step(16'h0, 0, 0, 16);
    foreach (seq[i]) for (int f = 0; f < 3; f++) step(16'(1) << seq[i], 0, 0, 16);
    step(16'h0004, ops4(0, 1, 1, 1), 4, 16);
    step(16'h0004, ops4(1, 0, 2, 0), 4, 16);
    for (int f = 0; f < 4; f++) step(16'h0040, 0, 0, 16);
    step(16'h0040, ops4(0, 0, 0, 0), 1, 7);
    apply_reset();
    for (int f = 0; f < 4; f++) step(16'h0040, ops4(0, 1, 0, 0), 2, 16);
    keys = 0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 2) == 0) keys = rnd_keys();
      step(keys, 8'($urandom), $urandom_range(0, 4), 16);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
